// File: rtl/frame_ram_pad_rd_if.sv
// frame_ram_pad_rd_if: write port, padded read request and output stream of the frame buffer
interface frame_ram_pad_rd_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int ROW_REAL_WIDTH = 6,
  parameter int COL_REAL_WIDTH = 6,
  parameter int COORD_WIDTH    = 8
);
  logic                      wr_en;
  logic [ROW_REAL_WIDTH-1:0] wr_row;
  logic [COL_REAL_WIDTH-1:0] wr_col;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic                      rd_vld;
  logic                      rd_rdy;
  logic [COORD_WIDTH-1:0]    rd_row;
  logic [COORD_WIDTH-1:0]    rd_col;
  logic [1:0]                pad_mode;
  logic                      dout_vld;
  logic                      dout_rdy;
  logic [DATA_WIDTH-1:0]     dout;
  modport master (
    output wr_en, wr_row, wr_col, wr_data, rd_vld, rd_row, rd_col, pad_mode, dout_rdy,
    input  rd_rdy, dout_vld, dout
  );
  modport slave (
    input  wr_en, wr_row, wr_col, wr_data, rd_vld, rd_row, rd_col, pad_mode, dout_rdy,
    output rd_rdy, dout_vld, dout
  );
endinterface

// File: rtl/frame_ram_pad_rd.sv
// frame_ram_pad_rd: frame RAM with signed padded reads (constant/replicate/mirror) and a 4-entry output FIFO; mirror mode built only with FRAME_RAM_PAD_MIRROR_EN
module frame_ram_pad_rd #(
  parameter int DATA_WIDTH     = 8,
  parameter int FRAME_WIDTH    = 64,
  parameter int FRAME_HEIGHT   = 52,
  parameter int ROW_REAL_WIDTH = 6,
  parameter int COL_REAL_WIDTH = 6,
  parameter int COORD_WIDTH    = 8,
  parameter int PAD_VALUE      = 128
) (
  input logic               clk,
  input logic               rst_n,
  frame_ram_pad_rd_if.slave bus
);
  localparam int AW = ROW_REAL_WIDTH + COL_REAL_WIDTH;
  function automatic int clamp_axis(input int e, input int n);
    return e < 0 ? 0 : (e > n - 1 ? n - 1 : e);
  endfunction
`ifdef FRAME_RAM_PAD_MIRROR_EN
  function automatic int mirror_axis(input int e, input int n);
    return e < 0 ? -e : (e > n - 1 ? 2 * (n - 1) - e : e);
  endfunction
`endif
  logic [DATA_WIDTH-1:0]     mem [2**AW];
  logic [DATA_WIDTH-1:0]     fifo [4];
  logic                      w_en;
  logic [AW-1:0]             w_addr;
  logic [DATA_WIDTH-1:0]     w_data;
  int                        r_in, c_in, r_sel, c_sel;
  logic                      use_pad, out_frame;
  logic [ROW_REAL_WIDTH-1:0] r_idx;
  logic [COL_REAL_WIDTH-1:0] c_idx;
  logic                      run, v1, v2, v3, p1, p2;
  logic [AW-1:0]             a1;
  logic [DATA_WIDTH-1:0]     q2, d3;
  logic [1:0]                wp, rp;
  logic [2:0]                cnt;
  logic                      acc, pop;
  assign pop          = bus.dout_vld && bus.dout_rdy;
  assign acc          = bus.rd_vld && bus.rd_rdy;
  assign bus.rd_rdy   = run && (4'(cnt) + 4'(v1) + 4'(v2) + 4'(v3) - 4'(pop) < 4'd4);
  assign bus.dout_vld = cnt != 3'd0;
  assign bus.dout     = cnt != 3'd0 ? fifo[rp] : '0;
  // Map the signed request coordinates to a legal RAM address and flag pixels that need the pad value
  always_comb begin
    r_in = int'($signed(bus.rd_row));
    c_in = int'($signed(bus.rd_col));
`ifdef FRAME_RAM_PAD_MIRROR_EN
    r_sel   = bus.pad_mode == 2'd2 ? mirror_axis(r_in, FRAME_HEIGHT) : r_in;
    c_sel   = bus.pad_mode == 2'd2 ? mirror_axis(c_in, FRAME_WIDTH) : c_in;
    use_pad = bus.pad_mode == 2'd0 || bus.pad_mode == 2'd3;
`else
    r_sel   = r_in;
    c_sel   = c_in;
    use_pad = bus.pad_mode != 2'd1;
`endif
    out_frame = r_in < 0 || r_in > FRAME_HEIGHT - 1 || c_in < 0 || c_in > FRAME_WIDTH - 1;
    r_idx     = ROW_REAL_WIDTH'(clamp_axis(r_sel, FRAME_HEIGHT));
    c_idx     = COL_REAL_WIDTH'(clamp_axis(c_sel, FRAME_WIDTH));
  end
  // Register the write port one cycle, discarding writes outside the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en   <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else begin
      w_en   <= bus.wr_en && 32'(bus.wr_row) < FRAME_HEIGHT && 32'(bus.wr_col) < FRAME_WIDTH;
      w_addr <= {bus.wr_row, bus.wr_col};
      w_data <= bus.wr_data;
    end
  end
  // Read-first RAM: a same-edge write to the read address returns the old word
  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
    q2 <= mem[a1];
  end
  // Three-stage read pipeline: map, RAM read, pad select; run holds rd_rdy low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      p1  <= 1'b0;
      p2  <= 1'b0;
      a1  <= '0;
      d3  <= '0;
    end else begin
      run <= 1'b1;
      v1  <= acc;
      if (acc) begin
        p1 <= use_pad && out_frame;
        a1 <= {r_idx, c_idx};
      end
      v2 <= v1;
      p2 <= p1;
      v3 <= v2;
      d3 <= p2 ? DATA_WIDTH'(PAD_VALUE) : q2;
    end
  end
  // FIFO storage, written by the last pipeline stage
  always_ff @(posedge clk) begin
    if (v3) fifo[wp] <= d3;
  end
  // FIFO pointers and occupancy; push and pop in the same cycle cancel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (v3) wp <= wp + 2'd1;
      if (pop) rp <= rp + 2'd1;
      cnt <= cnt + 3'(v3) - 3'(pop);
    end
  end
endmodule

// File: tb/tb_frame_ram_pad_rd.sv
// tb_frame_ram_pad_rd: randomized self-checking bench against a pixel-array reference model
module tb_frame_ram_pad_rd;
  localparam int W = 64;
  localparam int H = 52;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] img [H][W];
  logic [7:0] expq [$];

  frame_ram_pad_rd_if #(.DATA_WIDTH(8), .ROW_REAL_WIDTH(6), .COL_REAL_WIDTH(6), .COORD_WIDTH(8)) bus ();
  frame_ram_pad_rd #(
    .DATA_WIDTH(8), .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .ROW_REAL_WIDTH(6),
    .COL_REAL_WIDTH(6), .COORD_WIDTH(8), .PAD_VALUE(128)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic int clampi(int v, int lo, int hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction

  function automatic logic [7:0] ref_pix(int r, int c, int m);
    int rr, cc;
`ifdef FRAME_RAM_PAD_MIRROR_EN
    if (m == 2) begin
      rr = r < 0 ? -r : (r >= H ? 2 * (H - 1) - r : r);
      cc = c < 0 ? -c : (c >= W ? 2 * (W - 1) - c : c);
      return img[clampi(rr, 0, H - 1)][clampi(cc, 0, W - 1)];
    end
`endif
    if (m == 1) return img[clampi(r, 0, H - 1)][clampi(c, 0, W - 1)];
    if (r < 0 || r >= H || c < 0 || c >= W) return 8'd128;
    return img[r][c];
  endfunction

  function automatic int rand_coord();
    return $urandom_range(1) ? int'($urandom_range(255)) - 128 : int'($urandom_range(80)) - 10;
  endfunction

  task automatic write_px(int r, int c, logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.wr_row = 6'(r);
    bus.wr_col = 6'(c);
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (r < H && c < W) img[r][c] = d;
  endtask

  task automatic read_one(int r, int c, int m, output logic [7:0] d, output int lat);
    int t = 0;
    bus.rd_vld = 1'b1;
    bus.rd_row = 8'(r);
    bus.rd_col = 8'(c);
    bus.pad_mode = 2'(m);
    #1;
    while (!bus.rd_rdy && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    @(negedge clk);
    bus.rd_vld = 1'b0;
    lat = 0;
    while (!bus.dout_vld && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = (t < 20 && bus.dout_vld) ? bus.dout : 8'hxx;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (bus.rd_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rd_rdy: got %b expected 0", bus.rd_rdy); end
    n_chk++; if (bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL reset_dout_vld: got %b expected 0", bus.dout_vld); end
    n_chk++; if (bus.dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", bus.dout); end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.rd_rdy !== 1'b1) begin n_fail++; $display("FAIL rd_rdy_after_reset: got %b expected 1", bus.rd_rdy); end
  endtask

  task automatic test_fill();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) write_px(r, c, 8'((r * W + c) & 8'hFF));
    @(negedge clk);
  endtask

  task automatic test_in_frame();
    int rs [3] = '{0, 51, 10};
    int cs [3] = '{0, 63, 20};
    logic [7:0] ex [3] = '{8'h00, 8'hFF, 8'h94};
    logic [7:0] d;
    int lat;
    for (int i = 0; i < 3; i++) begin
      read_one(rs[i], cs[i], 0, d, lat);
      n_chk++; if (d !== ex[i]) begin n_fail++; $display("FAIL in_frame_%0d: got %h expected %h", i, d, ex[i]); end
      n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL latency_%0d: got %0d expected 3", i, lat); end
    end
  endtask

  task automatic test_pad_modes();
    int rs [10] = '{-1, 52, 0, -3, 60, -1, 0, -100, -1, 5};
    int cs [10] = '{5, 0, 64, -3, 70, 0, 64, 127, 0, -7};
    int ms [10] = '{0, 0, 0, 1, 1, 2, 2, 2, 3, 3};
    logic [7:0] d;
    int lat;
    for (int i = 0; i < 10; i++) begin
      read_one(rs[i], cs[i], ms[i], d, lat);
      n_chk++;
      if (d !== ref_pix(rs[i], cs[i], ms[i])) begin
        n_fail++;
        $display("FAIL pad_mode%0d_(%0d,%0d): got %h expected %h", ms[i], rs[i], cs[i], d, ref_pix(rs[i], cs[i], ms[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    int lat, r, c, m;
    for (int i = 0; i < 30; i++) write_px(int'($urandom_range(63)), int'($urandom_range(63)), 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      r = rand_coord();
      c = rand_coord();
      m = int'($urandom_range(3));
      read_one(r, c, m, d, lat);
      n_chk++;
      if (d !== ref_pix(r, c, m) || lat !== 3) begin
        n_fail++;
        $display("FAIL random_read_(%0d,%0d,m%0d): got %h lat %0d expected %h lat 3", r, c, m, d, lat, ref_pix(r, c, m));
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, cyc = 0, acc_stall = 0, r, c, m;
    logic [7:0] e;
    expq.delete();
    r = rand_coord(); c = rand_coord(); m = int'($urandom_range(3));
    while (got < 20 && cyc < 200) begin
      bus.dout_rdy = cyc >= 10;
      bus.rd_vld = sent < 20;
      bus.rd_row = 8'(r);
      bus.rd_col = 8'(c);
      bus.pad_mode = 2'(m);
      #1;
      if (bus.rd_vld && bus.rd_rdy) begin
        expq.push_back(ref_pix(r, c, m));
        sent++;
        if (cyc < 10) acc_stall++;
        r = rand_coord(); c = rand_coord(); m = int'($urandom_range(3));
      end
      if (cyc == 9) begin
        n_chk++; if (acc_stall !== 4) begin n_fail++; $display("FAIL stall_accepts: got %0d expected 4", acc_stall); end
        n_chk++; if (bus.rd_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_rd_rdy: got %b expected 0", bus.rd_rdy); end
        n_chk++;
        if (bus.dout_vld !== 1'b1 || expq.size() == 0 || bus.dout !== expq[0]) begin
          n_fail++;
          $display("FAIL stall_head: got vld %b dout %h expected vld 1 dout %h", bus.dout_vld, bus.dout, expq.size() ? expq[0] : 8'hxx);
        end
      end
      if (bus.dout_vld && bus.dout_rdy) begin
        e = expq.size() ? expq.pop_front() : 8'hxx;
        n_chk++; if (bus.dout !== e) begin n_fail++; $display("FAIL stream_%0d: got %h expected %h", got, bus.dout, e); end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.rd_vld = 1'b0;
    bus.dout_rdy = 1'b1;
    n_chk++; if (got !== 20) begin n_fail++; $display("FAIL stream_count: got %0d expected 20", got); end
  endtask

  task automatic test_write_read();
    logic [7:0] d, e;
    int lat, t = 0;
    expq.delete();
    expq.push_back(ref_pix(5, 5, 0));
    bus.wr_en = 1'b1; bus.wr_row = 6'd5; bus.wr_col = 6'd5; bus.wr_data = 8'hAA;
    bus.rd_vld = 1'b1; bus.rd_row = 8'd5; bus.rd_col = 8'd5; bus.pad_mode = 2'd0;
    @(negedge clk);
    bus.wr_en = 1'b0;
    img[5][5] = 8'hAA;
    expq.push_back(8'hAA);
    @(negedge clk);
    bus.rd_vld = 1'b0;
    while (expq.size() > 0 && t < 20) begin
      if (bus.dout_vld) begin
        e = expq.pop_front();
        n_chk++; if (bus.dout !== e) begin n_fail++; $display("FAIL write_then_read: got %h expected %h", bus.dout, e); end
      end
      @(negedge clk);
      t++;
    end
    n_chk++; if (expq.size() !== 0) begin n_fail++; $display("FAIL write_then_read_timeout: got %0d left expected 0", expq.size()); end
    write_px(60, 5, 8'h11);
    @(negedge clk);
    read_one(51, 5, 0, d, lat);
    n_chk++; if (d !== ref_pix(51, 5, 0)) begin n_fail++; $display("FAIL dropped_write: got %h expected %h", d, ref_pix(51, 5, 0)); end
    read_one(60, 5, 1, d, lat);
    n_chk++; if (d !== ref_pix(51, 5, 0)) begin n_fail++; $display("FAIL dropped_write_clamp: got %h expected %h", d, ref_pix(51, 5, 0)); end
  endtask

  task automatic test_reset_mid();
    int seen = 0, lat;
    logic [7:0] d;
    bus.dout_rdy = 1'b0;
    bus.rd_vld = 1'b1; bus.rd_row = 8'd3; bus.rd_col = 8'd4; bus.pad_mode = 2'd0;
    repeat (5) @(negedge clk);
    bus.rd_vld = 1'b0;
    n_chk++; if (bus.dout_vld !== 1'b1) begin n_fail++; $display("FAIL mid_pre_vld: got %b expected 1", bus.dout_vld); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL mid_reset_vld: got %b expected 0", bus.dout_vld); end
    n_chk++; if (bus.rd_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_rdy: got %b expected 0", bus.rd_rdy); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.dout_rdy = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.dout_vld) seen++;
    end
    n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL stale_after_reset: got %0d outputs expected 0", seen); end
    read_one(7, 9, 0, d, lat);
    n_chk++; if (d !== ref_pix(7, 9, 0) || lat !== 3) begin n_fail++; $display("FAIL post_reset_read: got %h lat %0d expected %h lat 3", d, lat, ref_pix(7, 9, 0)); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0;
    bus.rd_vld = 1'b0; bus.rd_row = '0; bus.rd_col = '0; bus.pad_mode = '0;
    bus.dout_rdy = 1'b1;
    test_reset();
    test_fill();
    test_in_frame();
    test_pad_modes();
    test_random();
    test_back_to_back();
    test_write_read();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
